writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-side producer for the core's register file.
- Collects completed results from two execution sources, the ALU and the load unit, over valid/ready handshakes.
- Buffers one result per source, arbitrates, and drives the register file write port (addr/data/enable).
- Keeps a per-register pending-write scoreboard so issue logic can detect RAW hazards on rs1/rs2.

Parameters:
- XLEN, 32, data width of results and of the register file.
- REG_ADDR_WIDTH, 5, register address width; 2**REG_ADDR_WIDTH architectural registers.

Ports:
- i_Clock  in  1  core clock; all state updates on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  global stall gate; low = hold all state, no accept, no write.
- i_Alu_Valid  in  1  ALU result present.
- o_Alu_Ready  out  1  ALU result accepted when Valid&&Ready.
- i_Alu_Rd  in  REG_ADDR_WIDTH  ALU destination register.
- i_Alu_Data  in  XLEN  ALU result.
- i_Load_Valid  in  1  load result present.
- o_Load_Ready  out  1  load handshake ready.
- i_Load_Rd  in  REG_ADDR_WIDTH  load destination register.
- i_Load_Data  in  XLEN  load result.
- i_Issue_Valid  in  1  an instruction with a destination register issues this cycle.
- i_Issue_Rd  in  REG_ADDR_WIDTH  its destination.
- i_Rs1_Addr  in  REG_ADDR_WIDTH  hazard query 1.
- i_Rs2_Addr  in  REG_ADDR_WIDTH  hazard query 2.
- o_Rs1_Busy  out  1  rs1 has a pending, not-yet-written producer.
- o_Rs2_Busy  out  1  rs2 has a pending, not-yet-written producer.
- o_Write_Enable  out  1  to register file i_Write_Enable.
- o_Write_Addr  out  REG_ADDR_WIDTH  to register file i_Write_Addr.
- o_Write_Data  out  XLEN  to register file i_Write_Data.

Behaviour:
Reset (synchronous):
- Both source buffers empty; all busy bits clear; round-robin pointer = LOAD.
- Outputs after reset: o_Write_Enable=0, o_Write_Addr=0, o_Write_Data=0, o_Rs*_Busy=0, o_*_Ready=1 once i_Enable is high.
- Reset mid-operation discards buffered results and pending bits.

Source buffers (one entry per source):
- o_X_Ready = i_Enable && (!buf_valid || buf granted this cycle), giving back-to-back throughput of 1/cycle per source when uncontended.
- Accept with rd==0: handshake completes, result is dropped, buffer untouched.

Arbiter, combinational over buffer registers:
- Only one buffer valid: grant it.
- Both valid: grant the round-robin pointer's source; pointer then flips to the other source.
- A single grant leaves the pointer pointing away from the granted source.

Write port:
- o_Write_Enable = i_Enable && grant.
- Addr/data are taken from the granted buffer; registered source, combinational mux.
- When o_Write_Enable=0, addr/data are driven to 0.

Latency:
- Handshake in cycle N; write port asserted in cycle N+1 if granted.
- Register file commits at the edge ending N+1.
- Worst case under contention is N+2.

Scoreboard (busy[1 .. 2**REG_ADDR_WIDTH-1]; bit 0 is hard 0):
- Set on i_Issue_Valid with rd!=0.
- Cleared on o_Write_Enable to that rd.
- Set and clear on the same rd in the same cycle: set wins.
- Upstream never issues to an already-busy rd; the bench asserts this.
- o_RsK_Busy = busy[rsK] && !(o_Write_Enable && o_Write_Addr==rsK). Same-cycle write is visible through the register file's write-read bypass.
- rsK==0 -> 0.
- Busy outputs are valid even when i_Enable=0; state is held.

Optional Feature:
Macro WRITEBACK_FORWARD_EN.
- Defined: adds ports o_Rs1_Fwd_Data and o_Rs2_Fwd_Data, each XLEN wide.
  - If any valid buffer holds rd==rsK (rsK!=0), o_RsK_Busy=0 and o_RsK_Fwd_Data is that buffer's data.
  - If both buffers match, the LOAD buffer wins (the later producer, since issue is in-order).
  - Otherwise o_RsK_Fwd_Data=0.
- Undefined: ports absent; Busy stays high until the write cycle, per the scoreboard rule.

Decomposition:
- cpu_core_params.vh: XLEN, REG_ADDR_WIDTH, and source encodings WB_SRC_ALU=1'b0, WB_SRC_LOAD=1'b1.
- Sub-module register_scoreboard: busy vector, set/clear/priority, and the two query ports with write-bypass masking.
- Buffers and arbiter stay in writeback_unit.

Test Plan:
- ALU Valid, rd=5, data=0x1234 in cycle 1 -> cycle 2 Write_Enable=1, Addr=5, Data=0x1234; busy[5] (issued cycle 0) reads 1 in cycle 1, 0 in cycle 2.
- Both sources valid every cycle: ALU rd=1..4, Load rd=9..12 -> writes alternate Load,ALU,Load,ALU starting with Load after reset; each Ready low exactly on alternate cycles.
- Load rd=0 data=0xFFFF -> handshake completes, no Write_Enable ever asserted, busy vector unchanged.
- Issue rd=7 and writeback rd=7 in the same cycle -> busy[7]=1 next cycle.
- Write_Enable to rd=3 with Rs1_Addr=3 -> o_Rs1_Busy=0 that cycle.
- i_Enable=0 for 3 cycles with both buffers full -> no write, Readys=0, then resume in order.
- Reset asserted with both buffers full -> next cycle no write, all Busy=0, Readys=1.
- With WRITEBACK_FORWARD_EN: Load buffer rd=8 data=0xABCD, Rs2_Addr=8 -> Rs2_Busy=0, Rs2_Fwd_Data=0xABCD.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared core widths and writeback source encodings.
// Imported by writeback_unit and register_scoreboard.
package writeback_unit_pkg;

   localparam int CORE_XLEN           = 32;
   localparam int CORE_REG_ADDR_WIDTH = 5;

   typedef enum logic {
      WB_SRC_ALU  = 1'b0,
      WB_SRC_LOAD = 1'b1
   } wb_src_e;

endpackage

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write bits with rs1/rs2 queries.
// Ports: i_Set_* (issue), i_Clear_* (write port), i_RsK_Addr -> o_RsK_Busy.
module register_scoreboard
   import writeback_unit_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Enable,
   input  logic                      i_Set_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Set_Addr,
   input  logic                      i_Clear_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Clear_Addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rs1_Addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rs2_Addr,
   output logic                      o_Rs1_Busy,
   output logic                      o_Rs2_Busy
);

   localparam int NREG = 2 ** REG_ADDR_WIDTH;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   // x0 is never set, so busy[0] stays 0 from reset onward.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (i_Set_Valid && i_Set_Addr != '0)
         set_mask[i_Set_Addr] = 1'b1;
      if (i_Clear_Valid)
         clr_mask[i_Clear_Addr] = 1'b1;
   end

   // Set is applied after clear so a same-cycle reissue stays pending.
   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         busy <= '0;
      else if (i_Enable)
         busy <= (busy & ~clr_mask) | set_mask;
   end

   // A register being written this cycle is readable via the RF bypass.
   assign o_Rs1_Busy = busy[i_Rs1_Addr] &&
                       !(i_Clear_Valid && i_Clear_Addr == i_Rs1_Addr);
   assign o_Rs2_Busy = busy[i_Rs2_Addr] &&
                       !(i_Clear_Valid && i_Clear_Addr == i_Rs2_Addr);

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: buffers ALU/load results, round-robin arbitrates onto the
// register file write port and tracks pending writes for hazard queries.
// Ports: ALU/load valid-ready inputs, issue/rs queries, RF write port.
// Optional macro WRITEBACK_FORWARD_EN adds o_Rs1_Fwd_Data/o_Rs2_Fwd_Data
// forwarding from the source buffers.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int XLEN           = CORE_XLEN,
   parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Enable,
   input  logic                      i_Alu_Valid,
   output logic                      o_Alu_Ready,
   input  logic [REG_ADDR_WIDTH-1:0] i_Alu_Rd,
   input  logic [XLEN-1:0]           i_Alu_Data,
   input  logic                      i_Load_Valid,
   output logic                      o_Load_Ready,
   input  logic [REG_ADDR_WIDTH-1:0] i_Load_Rd,
   input  logic [XLEN-1:0]           i_Load_Data,
   input  logic                      i_Issue_Valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Rd,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rs1_Addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rs2_Addr,
   output logic                      o_Rs1_Busy,
   output logic                      o_Rs2_Busy,
   output logic                      o_Write_Enable,
   output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr,
   output logic [XLEN-1:0]           o_Write_Data
`ifdef WRITEBACK_FORWARD_EN
   ,
   output logic [XLEN-1:0]           o_Rs1_Fwd_Data,
   output logic [XLEN-1:0]           o_Rs2_Fwd_Data
`endif
);

   logic                      alu_vld;
   logic [REG_ADDR_WIDTH-1:0] alu_rd;
   logic [XLEN-1:0]           alu_data;
   logic                      ld_vld;
   logic [REG_ADDR_WIDTH-1:0] ld_rd;
   logic [XLEN-1:0]           ld_data;
   wb_src_e                   rr_ptr;

   logic grant_alu;
   logic grant_ld;
   logic alu_acc;
   logic ld_acc;
   logic sb_busy1;
   logic sb_busy2;

   assign grant_alu = alu_vld && (!ld_vld || rr_ptr == WB_SRC_ALU);
   assign grant_ld  = ld_vld && (!alu_vld || rr_ptr == WB_SRC_LOAD);

   assign o_Alu_Ready  = i_Enable && (!alu_vld || grant_alu);
   assign o_Load_Ready = i_Enable && (!ld_vld || grant_ld);
   assign alu_acc      = i_Alu_Valid && o_Alu_Ready;
   assign ld_acc       = i_Load_Valid && o_Load_Ready;

   always_comb begin
      o_Write_Enable = i_Enable && (grant_alu || grant_ld);
      o_Write_Addr   = '0;
      o_Write_Data   = '0;
      if (o_Write_Enable) begin
         o_Write_Addr = grant_ld ? ld_rd : alu_rd;
         o_Write_Data = grant_ld ? ld_data : alu_data;
      end
   end

   // rd==0 results complete the handshake but never occupy a buffer.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         alu_vld  <= 1'b0;
         alu_rd   <= '0;
         alu_data <= '0;
         ld_vld   <= 1'b0;
         ld_rd    <= '0;
         ld_data  <= '0;
         rr_ptr   <= WB_SRC_LOAD;
      end else if (i_Enable) begin
         if (alu_acc && i_Alu_Rd != '0) begin
            alu_vld  <= 1'b1;
            alu_rd   <= i_Alu_Rd;
            alu_data <= i_Alu_Data;
         end else if (grant_alu) begin
            alu_vld  <= 1'b0;
         end
         if (ld_acc && i_Load_Rd != '0) begin
            ld_vld  <= 1'b1;
            ld_rd   <= i_Load_Rd;
            ld_data <= i_Load_Data;
         end else if (grant_ld) begin
            ld_vld  <= 1'b0;
         end
         if (grant_alu)
            rr_ptr <= WB_SRC_LOAD;
         else if (grant_ld)
            rr_ptr <= WB_SRC_ALU;
      end
   end

   register_scoreboard #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
   ) u_scoreboard (
      .i_Clock       (i_Clock),
      .i_Reset       (i_Reset),
      .i_Enable      (i_Enable),
      .i_Set_Valid   (i_Issue_Valid),
      .i_Set_Addr    (i_Issue_Rd),
      .i_Clear_Valid (o_Write_Enable),
      .i_Clear_Addr  (o_Write_Addr),
      .i_Rs1_Addr    (i_Rs1_Addr),
      .i_Rs2_Addr    (i_Rs2_Addr),
      .o_Rs1_Busy    (sb_busy1),
      .o_Rs2_Busy    (sb_busy2)
   );

`ifdef WRITEBACK_FORWARD_EN
   logic hit_alu1, hit_ld1, hit_alu2, hit_ld2;

   assign hit_alu1 = alu_vld && i_Rs1_Addr != '0 && alu_rd == i_Rs1_Addr;
   assign hit_ld1  = ld_vld && i_Rs1_Addr != '0 && ld_rd == i_Rs1_Addr;
   assign hit_alu2 = alu_vld && i_Rs2_Addr != '0 && alu_rd == i_Rs2_Addr;
   assign hit_ld2  = ld_vld && i_Rs2_Addr != '0 && ld_rd == i_Rs2_Addr;

   // The load is the younger producer when both buffers match.
   assign o_Rs1_Fwd_Data = hit_ld1 ? ld_data :
                           hit_alu1 ? alu_data : '0;
   assign o_Rs2_Fwd_Data = hit_ld2 ? ld_data :
                           hit_alu2 ? alu_data : '0;
   assign o_Rs1_Busy = sb_busy1 && !(hit_ld1 || hit_alu1);
   assign o_Rs2_Busy = sb_busy2 && !(hit_ld2 || hit_alu2);
`else
   assign o_Rs1_Busy = sb_busy1;
   assign o_Rs2_Busy = sb_busy2;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of buffering, arbitration, scoreboard.
// Inputs change and outputs are sampled just after the falling edge.
module tb_writeback_unit;

   localparam int XW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_rd;
   logic [XW-1:0] alu_data;
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_rd;
   logic [XW-1:0] ld_data;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic          busy1;
   logic          busy2;
   logic          we;
   logic [AW-1:0] waddr;
   logic [XW-1:0] wdata;
`ifdef WRITEBACK_FORWARD_EN
   logic [XW-1:0] fwd1;
   logic [XW-1:0] fwd2;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   writeback_unit dut (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Enable       (en),
      .i_Alu_Valid    (alu_valid),
      .o_Alu_Ready    (alu_ready),
      .i_Alu_Rd       (alu_rd),
      .i_Alu_Data     (alu_data),
      .i_Load_Valid   (ld_valid),
      .o_Load_Ready   (ld_ready),
      .i_Load_Rd      (ld_rd),
      .i_Load_Data    (ld_data),
      .i_Issue_Valid  (iss_valid),
      .i_Issue_Rd     (iss_rd),
      .i_Rs1_Addr     (rs1),
      .i_Rs2_Addr     (rs2),
      .o_Rs1_Busy     (busy1),
      .o_Rs2_Busy     (busy2),
      .o_Write_Enable (we),
      .o_Write_Addr   (waddr),
      .o_Write_Data   (wdata)
`ifdef WRITEBACK_FORWARD_EN
      ,
      .o_Rs1_Fwd_Data (fwd1),
      .o_Rs2_Fwd_Data (fwd2)
`endif
   );

   task automatic idle_inputs();
      en        = 1'b1;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      ld_valid  = 1'b0;
      ld_rd     = '0;
      ld_data   = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      rs1       = '0;
      rs2       = '0;
   endtask

   // Leaves the bench at the falling edge of the first post-reset cycle.
   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rs1 = 5'd5;
      rs2 = 5'd31;
      #1;
      n_chk++;
      if (we !== 1'b0) begin
         n_fail++; $display("FAIL reset_we got %0b want 0", we);
      end
      n_chk++;
      if (waddr !== 5'd0) begin
         n_fail++; $display("FAIL reset_addr got %0d want 0", waddr);
      end
      n_chk++;
      if (wdata !== 32'd0) begin
         n_fail++; $display("FAIL reset_data got %h want 0", wdata);
      end
      n_chk++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %0b%0b want 00", busy1, busy2);
      end
      n_chk++;
      if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %0b%0b want 11", alu_ready, ld_ready);
      end
   endtask

   task automatic test_alu_single();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd5;
      rs1       = 5'd5;
      #1;
      n_chk++;
      if (busy1 !== 1'b0) begin
         n_fail++; $display("FAIL alu_busy_c0 got %0b want 0", busy1);
      end
      @(negedge clk);
      iss_valid = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'h1234;
      #1;
      n_chk++;
      if (busy1 !== 1'b1 || alu_ready !== 1'b1 || we !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_c1 busy/ready/we got %0b%0b%0b want 110",
                  busy1, alu_ready, we);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      #1;
      n_chk++;
      if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin
         n_fail++;
         $display("FAIL alu_write got %0b/%0d/%h want 1/5/1234",
                  we, waddr, wdata);
      end
      n_chk++;
      if (busy1 !== 1'b0) begin
         n_fail++; $display("FAIL alu_busy_c2 got %0b want 0", busy1);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (we !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_c3 we/busy got %0b%0b want 00", we, busy1);
      end
   endtask

   task automatic test_contention();
      int alu_in [9];
      int ld_in  [9];
      int wr_exp [9];
      alu_in = '{1, 2, 2, 3, 3, 4, 4, 0, 0};
      ld_in  = '{9, 10, 11, 11, 12, 12, 0, 0, 0};
      wr_exp = '{0, 9, 1, 10, 2, 11, 3, 12, 4};
      do_reset();
      for (int c = 0; c < 9; c++) begin
         alu_valid = (alu_in[c] != 0);
         alu_rd    = AW'(alu_in[c]);
         alu_data  = 32'h100 + XW'(alu_in[c]);
         ld_valid  = (ld_in[c] != 0);
         ld_rd     = AW'(ld_in[c]);
         ld_data   = 32'h200 + XW'(ld_in[c]);
         #1;
         n_chk++;
         if (wr_exp[c] == 0) begin
            if (we !== 1'b0) begin
               n_fail++; $display("FAIL rr_we c%0d got %0b want 0", c, we);
            end
         end else if (we !== 1'b1 || waddr !== AW'(wr_exp[c]) ||
                      wdata !== ((wr_exp[c] >= 9 ? 32'h200 : 32'h100)
                                 + XW'(wr_exp[c]))) begin
            n_fail++;
            $display("FAIL rr_write c%0d got %0b/%0d/%h want rd %0d",
                     c, we, waddr, wdata, wr_exp[c]);
         end
         if (c >= 1 && c <= 7) begin
            n_chk++;
            if (alu_ready !== c[0] ? 1'b0 : 1'b1) begin
            end
            if (alu_ready !== ~c[0] || ld_ready !== c[0]) begin
               n_fail++;
               $display("FAIL rr_ready c%0d got alu %0b load %0b want %0b %0b",
                        c, alu_ready, ld_ready, ~c[0], c[0]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load_rd0();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd6;
      rs1       = 5'd6;
      @(negedge clk);
      iss_valid = 1'b0;
      ld_valid  = 1'b1;
      ld_rd     = 5'd0;
      ld_data   = 32'hFFFF;
      #1;
      n_chk++;
      if (ld_ready !== 1'b1) begin
         n_fail++; $display("FAIL rd0_ready got %0b want 1", ld_ready);
      end
      @(negedge clk);
      ld_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++;
         if (we !== 1'b0 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_c%0d we/busy got %0b%0b want 01", k, we, busy1);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_set_wins();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd7;
      @(negedge clk);
      iss_valid = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd7;
      alu_data  = 32'h77;
      @(negedge clk);
      alu_valid = 1'b0;
      iss_valid = 1'b1;
      iss_rd    = 5'd7;
      rs1       = 5'd7;
      #1;
      n_chk++;
      if (we !== 1'b1 || waddr !== 5'd7) begin
         n_fail++; $display("FAIL setwin_write got %0b/%0d want 1/7", we, waddr);
      end
      @(negedge clk);
      iss_valid = 1'b0;
      #1;
      n_chk++;
      if (busy1 !== 1'b1) begin
         n_fail++; $display("FAIL setwin_busy got %0b want 1", busy1);
      end
   endtask

   task automatic test_bypass();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd3;
      rs1       = 5'd3;
      rs2       = 5'd3;
      @(negedge clk);
      iss_valid = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd3;
      alu_data  = 32'h33;
      #1;
      n_chk++;
      if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
         n_fail++; $display("FAIL byp_pending got %0b%0b want 11", busy1, busy2);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      #1;
      n_chk++;
      if (we !== 1'b1 || waddr !== 5'd3 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL byp_write we/addr/busy got %0b/%0d/%0b%0b want 1/3/00",
                  we, waddr, busy1, busy2);
      end
   endtask

   task automatic test_stall();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd21;
      rs1       = 5'd21;
      alu_valid = 1'b1;
      alu_rd    = 5'd20;
      alu_data  = 32'h20;
      ld_valid  = 1'b1;
      ld_rd     = 5'd21;
      ld_data   = 32'h21;
      @(negedge clk);
      iss_valid = 1'b0;
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      en        = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++;
         if (we !== 1'b0 || alu_ready !== 1'b0 || ld_ready !== 1'b0 ||
             busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_c%0d we/rdy/rdy/busy got %0b%0b%0b%0b want 0001",
                     k, we, alu_ready, ld_ready, busy1);
         end
         @(negedge clk);
      end
      en = 1'b1;
      #1;
      n_chk++;
      if (we !== 1'b1 || waddr !== 5'd21 || wdata !== 32'h21) begin
         n_fail++;
         $display("FAIL stall_first got %0b/%0d/%h want 1/21/21", we, waddr, wdata);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (we !== 1'b1 || waddr !== 5'd20 || wdata !== 32'h20) begin
         n_fail++;
         $display("FAIL stall_second got %0b/%0d/%h want 1/20/20", we, waddr, wdata);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd15;
      rs1       = 5'd15;
      rs2       = 5'd13;
      alu_valid = 1'b1;
      alu_rd    = 5'd13;
      alu_data  = 32'h13;
      ld_valid  = 1'b1;
      ld_rd     = 5'd14;
      ld_data   = 32'h14;
      @(negedge clk);
      iss_valid = 1'b0;
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if (we !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_state we/busy got %0b/%0b%0b want 0/00",
                  we, busy1, busy2);
      end
      n_chk++;
      if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready got %0b%0b want 11", alu_ready, ld_ready);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (we !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_nowrite got %0b want 0", we);
      end
   endtask

`ifdef WRITEBACK_FORWARD_EN
   task automatic test_forward();
      do_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd8;
      rs2       = 5'd8;
      @(negedge clk);
      iss_valid = 1'b0;
      ld_valid  = 1'b1;
      ld_rd     = 5'd8;
      ld_data   = 32'hABCD;
      #1;
      n_chk++;
      if (busy2 !== 1'b1 || fwd2 !== 32'd0) begin
         n_fail++; $display("FAIL fwd_pre got %0b/%h want 1/0", busy2, fwd2);
      end
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      n_chk++;
      if (busy2 !== 1'b0 || fwd2 !== 32'hABCD) begin
         n_fail++; $display("FAIL fwd_hit got %0b/%h want 0/abcd", busy2, fwd2);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_alu_single();
      test_contention();
      test_load_rd0();
      test_set_wins();
      test_bypass();
      test_stall();
      test_reset_mid();
`ifdef WRITEBACK_FORWARD_EN
      test_forward();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
